// File: rtl/msnw_pkg.sv
// msnw_pkg: shared definitions for the message network.
//   MSNW_PKT_WIDTH  - packet width in bits
//   msnw_pkt_t      - packet type
//   msnw_parity_ok  - even-parity check. The master-side parity generator uses
//                     the same function, so both ends agree on the definition.
package msnw_pkg;

  localparam int MSNW_PKT_WIDTH = 64;

  typedef logic [MSNW_PKT_WIDTH-1:0] msnw_pkt_t;

  // A packet is good when checking is off, or when all of its bits XOR to 0.
  function automatic logic msnw_parity_ok(msnw_pkt_t p, logic en);
    return !en || !(^p);
  endfunction

endpackage

// File: rtl/msnw_sync_fifo.sv
// msnw_sync_fifo: single-clock FIFO with registered storage.
//   clk, rstb       - clock, asynchronous active-low reset (control state only)
//   push, wdata     - write request and data; ignored when full unless popping
//   pop, rdata      - read request and head of FIFO; pop is ignored when empty
//   full, empty     - occupancy flags
//   count           - current occupancy
//   count_next      - occupancy after this cycle's push/pop
// A push and a pop in the same cycle both take effect, including when full.
// The pointers wrap naturally because DEPTH is a power of 2.
module msnw_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a push fits only because the pop frees the head slot.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (!do_push && do_pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Storage carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/msnw_rx_buffer.sv
// msnw_rx_buffer: slave-side receive stage of the message network.
// Checks even parity on request, captures rejected packets, buffers good
// packets in a FIFO and throttles the master with a registered xoff.
//   clk, rstb     - clock, asynchronous active-low reset
//   msnw_pkt      - incoming packet, qualified by valid
//   parity_en     - check parity on this packet (sampled with valid)
//   xoff          - registered flow control back to the master
//   parity_error  - one-cycle pulse per rejected packet
//   error_pkt     - last packet that failed parity
//   out_pkt       - head of FIFO (don't-care while out_valid=0)
//   out_valid     - FIFO not empty
//   out_ready     - downstream accepts out_pkt
//   fill_level    - FIFO occupancy
//   overflow      - sticky: a good packet was dropped on a full FIFO
//   err_count     - saturating parity-failure counter; exists only when
//                   MSNW_RX_ERR_CNT_EN is defined (with parameter ERR_CNT_WIDTH)
module msnw_rx_buffer #(
  parameter int MSNW_PKT_WIDTH = 64,
  parameter int DEPTH          = 8,
  parameter int XOFF_SLACK     = 3
`ifdef MSNW_RX_ERR_CNT_EN
  ,
  parameter int ERR_CNT_WIDTH  = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic [MSNW_PKT_WIDTH-1:0]  msnw_pkt,
  input  logic                       valid,
  input  logic                       parity_en,
  output logic                       xoff,
  output logic                       parity_error,
  output logic [MSNW_PKT_WIDTH-1:0]  error_pkt,
  output logic [MSNW_PKT_WIDTH-1:0]  out_pkt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow
`ifdef MSNW_RX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0]   err_count
`endif
);

  import msnw_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             pkt_ok;
  logic             pkt_bad;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count_next;

  // The cast zero-extends narrower packets, which leaves parity unchanged.
  assign pkt_ok  = msnw_parity_ok(msnw_pkt_t'(msnw_pkt), parity_en);
  assign pkt_bad = valid && !pkt_ok;
  assign pop     = out_valid && out_ready;
  assign push    = valid && pkt_ok && (!full || pop);

  msnw_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MSNW_PKT_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rstb       (rstb),
    .push       (push),
    .pop        (pop),
    .wdata      (msnw_pkt),
    .rdata      (out_pkt),
    .full       (full),
    .empty      (empty),
    .count      (fill_level),
    .count_next (count_next)
  );

  assign out_valid = !empty;

  // Register stage: flow control, error capture and overflow flag.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      xoff         <= 1'b0;
      parity_error <= 1'b0;
      error_pkt    <= '0;
      overflow     <= 1'b0;
    end else begin
      // Uses the post-update occupancy so xoff leaves XOFF_SLACK entries of
      // headroom for packets already in flight when the master sees it.
      xoff         <= (count_next >= CNT_W'(DEPTH - XOFF_SLACK));
      parity_error <= pkt_bad;
      if (pkt_bad)
        error_pkt <= msnw_pkt;
      // Only good packets count as drops; parity failures never set overflow.
      if (valid && pkt_ok && full && !pop)
        overflow <= 1'b1;
    end
  end

`ifdef MSNW_RX_ERR_CNT_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      err_count <= '0;
    else if (pkt_bad && (err_count != '1))
      err_count <= err_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_msnw_rx_buffer.sv
module tb_msnw_rx_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstb;
  logic [63:0] msnw_pkt;
  logic        valid;
  logic        parity_en;
  logic        xoff;
  logic        parity_error;
  logic [63:0] error_pkt;
  logic [63:0] out_pkt;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fill_level;
  logic        overflow;
`ifdef MSNW_RX_ERR_CNT_EN
  logic [1:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  msnw_rx_buffer #(
    .MSNW_PKT_WIDTH (64),
    .DEPTH          (DEPTH),
    .XOFF_SLACK     (3)
`ifdef MSNW_RX_ERR_CNT_EN
    ,
    .ERR_CNT_WIDTH  (2)
`endif
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .msnw_pkt     (msnw_pkt),
    .valid        (valid),
    .parity_en    (parity_en),
    .xoff         (xoff),
    .parity_error (parity_error),
    .error_pkt    (error_pkt),
    .out_pkt      (out_pkt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fill_level   (fill_level),
    .overflow     (overflow)
`ifdef MSNW_RX_ERR_CNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  // Scoreboard consumer: every handshake must deliver the oldest expected packet.
  always @(negedge clk) begin
    if (rstb && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_pop unexpected out_pkt=%h with empty scoreboard", out_pkt);
      end else begin
        logic [63:0] exp;
        exp = sb.pop_front();
        if (out_pkt !== exp) begin
          errors++;
          $display("FAIL sb_data got %h expected %h", out_pkt, exp);
        end
      end
    end
  end

  // Drive one cycle of input; record expected packets that should be stored.
  task automatic cyc(input logic [63:0] p, input logic v, input logic pen);
    logic ok;
    logic popm;
    msnw_pkt  = p;
    valid     = v;
    parity_en = pen;
    ok   = !pen || !(^p);
    popm = (sb.size() > 0) && out_ready;
    if (rstb && v && ok && (sb.size() < DEPTH || popm))
      sb.push_back(p);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstb  = 1'b0;
    valid = 1'b0;
    #2;
    sb.delete();
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b0; valid = 1'b1; msnw_pkt = 64'h3; parity_en = 1'b1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (xoff !== 1'b0)         begin errors++; $display("FAIL rst_xoff got %b expected 0", xoff); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL rst_perr got %b expected 0", parity_error); end
    checks++; if (error_pkt !== 64'h0)   begin errors++; $display("FAIL rst_epkt got %h expected 0", error_pkt); end
    checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL rst_oval got %b expected 0", out_valid); end
    checks++; if (fill_level !== 4'd0)   begin errors++; $display("FAIL rst_fill got %0d expected 0", fill_level); end
    checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL rst_ovf got %b expected 0", overflow); end
`ifdef MSNW_RX_ERR_CNT_EN
    checks++; if (err_count !== 2'd0)    begin errors++; $display("FAIL rst_errcnt got %0d expected 0", err_count); end
`endif
    @(negedge clk);
    rstb = 1'b1; valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL post_rst_oval got %b expected 0", out_valid); end
    checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL post_rst_fill got %0d expected 0", fill_level); end
    checks++; if (xoff !== 1'b0)       begin errors++; $display("FAIL post_rst_xoff got %b expected 0", xoff); end
  endtask

  task automatic test_single_pass();
    out_ready = 1'b1;
    cyc(64'h3, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1)    begin errors++; $display("FAIL sp_oval got %b expected 1", out_valid); end
    checks++; if (out_pkt !== 64'h3)     begin errors++; $display("FAIL sp_data got %h expected 3", out_pkt); end
    checks++; if (fill_level !== 4'd1)   begin errors++; $display("FAIL sp_fill got %0d expected 1", fill_level); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL sp_perr got %b expected 0", parity_error); end
    cyc(64'h0, 1'b0, 1'b0);
    checks++; if (fill_level !== 4'd0)   begin errors++; $display("FAIL sp_drain got %0d expected 0", fill_level); end
    checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL sp_oval_end got %b expected 0", out_valid); end
  endtask

  task automatic test_parity();
    out_ready = 1'b1;
    cyc(64'h1, 1'b1, 1'b1);
    checks++; if (parity_error !== 1'b1) begin errors++; $display("FAIL par_pulse got %b expected 1", parity_error); end
    checks++; if (error_pkt !== 64'h1)   begin errors++; $display("FAIL par_epkt got %h expected 1", error_pkt); end
    checks++; if (fill_level !== 4'd0)   begin errors++; $display("FAIL par_fill got %0d expected 0", fill_level); end
    cyc(64'h0, 1'b0, 1'b0);
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL par_pulse_end got %b expected 0", parity_error); end
    checks++; if (error_pkt !== 64'h1)   begin errors++; $display("FAIL par_epkt_hold got %h expected 1", error_pkt); end
    cyc(64'h1, 1'b1, 1'b0);
    checks++; if (fill_level !== 4'd1)   begin errors++; $display("FAIL par_off_accept got %0d expected 1", fill_level); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL par_off_perr got %b expected 0", parity_error); end
    cyc(64'h7, 1'b1, 1'b1);
    checks++; if (error_pkt !== 64'h7)   begin errors++; $display("FAIL par_epkt2 got %h expected 7", error_pkt); end
    cyc(64'h0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      cyc({32'hA5A5_0000, 32'(i)}, 1'b1, 1'b0);
      if (i == 4) begin
        checks++; if (xoff !== 1'b0) begin errors++; $display("FAIL bp_xoff4 got %b expected 0", xoff); end
      end
      if (i == 5) begin
        checks++; if (xoff !== 1'b1) begin errors++; $display("FAIL bp_xoff5 got %b expected 1", xoff); end
      end
    end
    valid = 1'b0;
    checks++; if (fill_level !== 4'd8) begin errors++; $display("FAIL bp_fill got %0d expected 8", fill_level); end
    checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL bp_ovf got %b expected 1", overflow); end
    checks++; if (out_pkt !== 64'hA5A5_0000_0000_0001) begin errors++; $display("FAIL bp_head got %h expected a5a5000000000001", out_pkt); end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && fill_level != 4'd0; i++) begin
      cyc(64'h0, 1'b0, 1'b0);
      checks++;
      if (xoff !== (fill_level >= 4'd5)) begin
        errors++; $display("FAIL bp_drain_xoff got %b at fill %0d", xoff, fill_level);
      end
    end
    checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL bp_empty got %0d expected 0", fill_level); end
    checks++; if (sb.size() != 0)      begin errors++; $display("FAIL bp_sb_left got %0d expected 0", sb.size()); end
    checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL bp_ovf_sticky got %b expected 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      cyc(64'hB0 + 64'(i), 1'b1, 1'b0);
    checks++; if (fill_level !== 4'd8) begin errors++; $display("FAIL fp_fill got %0d expected 8", fill_level); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL fp_ovf got %b expected 0", overflow); end
    cyc(64'h1, 1'b1, 1'b1);
    checks++; if (parity_error !== 1'b1) begin errors++; $display("FAIL fp_perr got %b expected 1", parity_error); end
    checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL fp_perr_ovf got %b expected 0", overflow); end
    out_ready = 1'b1;
    cyc(64'hC0, 1'b1, 1'b0);
    checks++; if (fill_level !== 4'd8) begin errors++; $display("FAIL fp_pp_fill got %0d expected 8", fill_level); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL fp_pp_ovf got %b expected 0", overflow); end
    checks++; if (out_pkt !== sb[0])   begin errors++; $display("FAIL fp_pp_head got %h expected %h", out_pkt, sb[0]); end
    cyc(64'hC1, 1'b1, 1'b0);
    #2;
    rstb = 1'b0;
    #1;
    checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL ar_fill got %0d expected 0", fill_level); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL ar_oval got %b expected 0", out_valid); end
    sb.delete();
    @(negedge clk);
    rstb = 1'b1; valid = 1'b0;
    cyc(64'h0, 1'b0, 1'b0);
    cyc(64'h0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_post_oval got %b expected 0", out_valid); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL ar_post_ovf got %b expected 0", overflow); end
  endtask

`ifdef MSNW_RX_ERR_CNT_EN
  task automatic test_err_count();
    logic [1:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(64'h7, 1'b1, 1'b1);
      exp = (i < 3) ? 2'(i + 1) : 2'd3;
      checks++;
      if (err_count !== exp) begin
        errors++; $display("FAIL errcnt_%0d got %0d expected %0d", i, err_count, exp);
      end
    end
    valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_pass();
    test_parity();
    test_backpressure();
    test_full_push_pop();
`ifdef MSNW_RX_ERR_CNT_EN
    test_err_count();
`endif
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
